pattern_loader: RTL and testbench
=================================

Name: pattern_loader

Overview:
- Writer end of the pattern-selection path. On a start pulse, captures the 2-bit switch selection and streams the chosen seed pattern (glider, blinker, beacon or acorn) into the Game of Life grid memory.
- Writes one cell per accepted cycle, in row-major order. Every cell outside the pattern is written 0.
- Sits between the user switches/button and the grid RAM write port. It replaces ad-hoc per-cell pattern muxing with a sequenced, backpressure-aware load.

Parameters:
- ROWS, 16, grid height in cells.
- COLS, 16, grid width in cells.
- ADDR_W, 8, width of wr_addr. Must satisfy 2^ADDR_W >= ROWS*COLS.
- ORIGIN_ROW, 2, row of the pattern's top-left bounding-box corner.
- ORIGIN_COL, 2, column of the pattern's top-left bounding-box corner.
- Constraint: ORIGIN_ROW+4 <= ROWS and ORIGIN_COL+7 <= COLS.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sel  input  2  raw switch pattern select: 00 glider, 01 blinker, 10 beacon, 11 acorn.
- start  input  1  single-cycle, already-debounced load request.
- wr_ready  input  1  grid memory accepts a write this cycle.
- wr_en  output  1  write valid.
- wr_addr  output  ADDR_W  cell address = row*COLS + col.
- wr_data  output  1  cell value (1 = alive).
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse after the last cell is accepted.
- sel_latched  output  2  selection captured for the current or last load.

Behaviour:
- Reset: asynchronous, active-high. When rst is asserted, state goes to IDLE, and wr_en, wr_addr, wr_data, busy, done, sel_latched and the row/col counters all become 0. The sel synchronizer flops also clear.
- Switch synchronizer: sel passes through 2 flops (sel_s). A switch change must be stable for at least 2 cycles before start to be captured.
- State IDLE:
  - Outputs: busy=0, wr_en=0.
  - If start=1 at an edge: sel_latched <= sel_s, row=col=0, go to WRITE.
- State WRITE:
  - Outputs: busy=1, wr_en=1, wr_addr = row*COLS+col, wr_data = pattern(sel_latched, row-ORIGIN_ROW, col-ORIGIN_COL).
  - Advance only on an edge where wr_ready=1. Then col increments; on col=COLS-1, col wraps to 0 and row increments.
  - When the cell at row=ROWS-1, col=COLS-1 is accepted, go to DONE.
  - While wr_ready=0: wr_addr and wr_data hold, wr_en stays 1.
- State DONE:
  - Outputs: done=1, busy=0, wr_en=0. Lasts exactly 1 cycle, then IDLE.
- Row and column are tracked with separate counters; no divider.
- Latency: with wr_ready held at 1 and start sampled at edge 0:
  - wr_en is high in cycles 1..ROWS*COLS.
  - done is high in cycle ROWS*COLS+1.
- Ignored inputs: start is ignored in WRITE and DONE. sel changes during WRITE do not affect the current load.
- Pattern cells are relative (r,c) offsets within the bounding box; any other offset, including negative ones, is 0:
  - glider: (0,1) (1,2) (2,0) (2,1) (2,2)
  - blinker: (1,0) (1,1) (1,2)
  - beacon: (0,0) (0,1) (1,0) (1,1) (2,2) (2,3) (3,2) (3,3)
  - acorn: (0,1) (1,3) (2,0) (2,1) (2,4) (2,5) (2,6)
- Reset mid-load: the sequence aborts with no done pulse. Outputs go to their reset values immediately, asynchronously. The next start begins again from address 0.

Test Plan:
1. Glider: sel=00 held ≥2 cycles, start pulse, wr_ready=1 → 256 writes, addresses 0..255 in order. wr_data=1 only at 35, 52, 66, 67, 68. done high exactly 1 cycle, at cycle 257. sel_latched=00.
2. Blinker, beacon and acorn (sel=01/10/11), each with a start pulse → wr_data=1 only at:
   - blinker: {50, 51, 52}
   - beacon: {34, 35, 50, 51, 68, 69, 84, 85}
   - acorn: {35, 53, 66, 67, 70, 71, 72}
3. Backpressure: acorn with wr_ready toggling pseudo-randomly → wr_addr and wr_data stable while wr_ready=0. No address is skipped or repeated among accepted writes. Same 7 live addresses as scenario 2. done follows the 256th accepted write.
4. Ignored inputs: start re-pulsed and sel changed 00→11 at accepted address 40 of a glider load → load continues unchanged, sel_latched stays 00, exactly 256 writes and one done.
5. Reset mid-load: rst asserted when wr_addr=100 → same cycle wr_en=0, busy=0, wr_addr=0, done never pulses. After rst is released, a fresh blinker load completes correctly.
6. Synchronizer: sel changed 1 cycle before start → the previous selection is captured in sel_latched. sel changed 2 cycles before start → the new selection is captured.

Source files
------------

// File: rtl/pattern_loader_if.sv
// Grid-memory write port: one cell per accepted cycle, valid/ready style.
interface pattern_loader_if #(
    parameter int ADDR_W = 8
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_data;
    logic              wr_ready;

    modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/pattern_loader.sv
// Streams a selected Game of Life seed pattern into grid memory, one cell per
// accepted write, row-major, honouring wr_ready backpressure.
module pattern_loader #(
    parameter int ROWS       = 16,
    parameter int COLS       = 16,
    parameter int ADDR_W     = 8,
    parameter int ORIGIN_ROW = 2,
    parameter int ORIGIN_COL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic       start,
    pattern_loader_if.master wr,
    output logic       busy,
    output logic       done,
    output logic [1:0] sel_latched
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE} state_t;

    state_t          state;
    logic [1:0]      sel_m;
    logic [1:0]      sel_s;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic [RW-1:0]   nxt_row;
    logic [CW-1:0]   nxt_col;
    logic            last_col;
    logic            last_cell;

    // Each pattern is a 4x8 bitmap, bit index = r*8 + c within the bounding box.
    function automatic logic cell_on(input logic [1:0] s, input int r, input int c);
        logic [31:0] map;
        logic [4:0]  idx;
        case (s)
            2'b00:   map = 32'h0007_0402;
            2'b01:   map = 32'h0000_0700;
            2'b10:   map = 32'h0C0C_0303;
            default: map = 32'h0073_0802;
        endcase
        idx = 5'((r << 3) + c);
        if (r >= 0 && r < 4 && c >= 0 && c < 8)
            cell_on = map[idx];
        else
            cell_on = 1'b0;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_m <= '0;
            sel_s <= '0;
        end else begin
            sel_m <= sel;
            sel_s <= sel_m;
        end
    end

    always_comb begin
        last_col  = (col == CW'(COLS - 1));
        last_cell = last_col && (row == RW'(ROWS - 1));
        nxt_col   = last_col ? '0 : col + CW'(1);
        nxt_row   = last_col ? row + RW'(1) : row;
    end

    // wr_addr and wr_data are registered one step ahead, computed from the next row/col.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            wr.wr_en    <= 1'b0;
            wr.wr_addr  <= '0;
            wr.wr_data  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sel_latched <= '0;
            row         <= '0;
            col         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sel_latched <= sel_s;
                        row         <= '0;
                        col         <= '0;
                        wr.wr_addr  <= '0;
                        wr.wr_data  <= cell_on(sel_s, -ORIGIN_ROW, -ORIGIN_COL);
                        wr.wr_en    <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (wr.wr_ready) begin
                        if (last_cell) begin
                            wr.wr_en <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            row        <= nxt_row;
                            col        <= nxt_col;
                            wr.wr_addr <= wr.wr_addr + ADDR_W'(1);
                            wr.wr_data <= cell_on(sel_latched,
                                                  int'(nxt_row) - ORIGIN_ROW,
                                                  int'(nxt_col) - ORIGIN_COL);
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    wr.wr_en <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_loader.sv
// Directed bench for pattern_loader: every pattern, backpressure, ignored
// inputs, mid-load reset and the sel synchronizer.
module tb_pattern_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic       start;
    logic       busy;
    logic       done;
    logic [1:0] sel_latched;
    int         n_assert = 0;
    int         n_fail   = 0;

    pattern_loader_if #(.ADDR_W(8)) wif();

    pattern_loader #(
        .ROWS(16), .COLS(16), .ADDR_W(8), .ORIGIN_ROW(2), .ORIGIN_COL(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sel(sel),
        .start(start),
        .wr(wif),
        .busy(busy),
        .done(done),
        .sel_latched(sel_latched)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Live cell addresses on the 16x16 grid with the pattern box at (2,2).
    function automatic bit exp_live(input logic [1:0] s, input int a);
        case (s)
            2'b00:   return a == 35 || a == 52 || a == 66 || a == 67 || a == 68;
            2'b01:   return a == 50 || a == 51 || a == 52;
            2'b10:   return a == 34 || a == 35 || a == 50 || a == 51 ||
                            a == 68 || a == 69 || a == 84 || a == 85;
            default: return a == 35 || a == 53 || a == 66 || a == 67 ||
                            a == 70 || a == 71 || a == 72;
        endcase
    endfunction

    task automatic run_load(input logic [1:0] s, input int pre, input logic [1:0] exp_sel,
                            input bit bp, input bit disturb);
        int accepted  = 0;
        int budget    = 0;
        bit disturbed = 1'b0;
        sel = s;
        repeat (pre) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (accepted < 256 && budget < 3000) begin
            budget++;
            if (wif.wr_en !== 1'b1) begin
                check("wr_en_during_load", 32'(wif.wr_en), 32'd1);
                break;
            end
            check("wr_addr", 32'(wif.wr_addr), 32'(accepted));
            check("wr_data", 32'(wif.wr_data), 32'(exp_live(exp_sel, accepted)));
            check("busy_in_load", 32'(busy), 32'd1);
            check("done_early", 32'(done), 32'd0);
            start = 1'b0;
            if (disturb && !disturbed && accepted == 40) begin
                start     = 1'b1;
                sel       = 2'b11;
                disturbed = 1'b1;
            end
            wif.wr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wif.wr_ready) accepted++;
            @(negedge clk);
        end
        start = 1'b0;
        check("accepted_count", 32'(accepted), 32'd256);
        check("done_pulse", 32'(done), 32'd1);
        check("wr_en_at_done", 32'(wif.wr_en), 32'd0);
        check("busy_at_done", 32'(busy), 32'd0);
        check("sel_latched", 32'(sel_latched), 32'(exp_sel));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("wr_en_idle", 32'(wif.wr_en), 32'd0);
        @(negedge clk);
        check("no_restart", 32'(wif.wr_en), 32'd0);
    endtask

    initial begin
        int b;
        rst          = 1'b1;
        sel          = 2'b00;
        start        = 1'b0;
        wif.wr_ready = 1'b0;
        #12;
        check("rst_wr_en", 32'(wif.wr_en), 32'd0);
        check("rst_wr_addr", 32'(wif.wr_addr), 32'd0);
        check("rst_wr_data", 32'(wif.wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sel_latched", 32'(sel_latched), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_load(2'b00, 3, 2'b00, 1'b0, 1'b0);
        run_load(2'b01, 3, 2'b01, 1'b0, 1'b0);
        run_load(2'b10, 3, 2'b10, 1'b0, 1'b0);
        run_load(2'b11, 3, 2'b11, 1'b0, 1'b0);
        run_load(2'b11, 3, 2'b11, 1'b1, 1'b0);
        run_load(2'b00, 3, 2'b00, 1'b0, 1'b1);

        sel = 2'b00;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        wif.wr_ready = 1'b1;
        b = 0;
        while (wif.wr_addr !== 8'd100 && b < 500) begin
            check("done_before_rst", 32'(done), 32'd0);
            @(negedge clk);
            b++;
        end
        check("reached_addr_100", 32'(wif.wr_addr), 32'd100);
        #2 rst = 1'b1;
        #1;
        check("midrst_wr_en", 32'(wif.wr_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_wr_addr", 32'(wif.wr_addr), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("done_in_rst", 32'(done), 32'd0);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("done_after_rst", 32'(done), 32'd0);
            check("wr_en_after_rst", 32'(wif.wr_en), 32'd0);
        end
        run_load(2'b01, 3, 2'b01, 1'b0, 1'b0);

        run_load(2'b10, 1, 2'b01, 1'b0, 1'b0);
        run_load(2'b11, 2, 2'b11, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
